// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM among NREQ masters.
// Fixed latency: gnt at T, RAM enable at T+1, done and rdata at T+2.
module mem_arbiter #(
  parameter int NREQ      = 2,
  parameter int DWIDTH    = 32,
  parameter int CPUAWIDTH = 32,
  parameter int AWIDTH    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ*CPUAWIDTH-1:0] addr,
  input  logic [NREQ*DWIDTH-1:0]    wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [NREQ-1:0]           err,
  output logic [DWIDTH-1:0]         rdata,
  output logic [AWIDTH-1:0]         ram_addr,
  output logic                      ram_rd_en,
  output logic                      ram_wr_en,
  output logic [DWIDTH-1:0]         ram_wdata,
  input  logic [DWIDTH-1:0]         ram_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     win_q, win_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] waddr_q, waddr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;

  logic                 found;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        pick_nxt;
  logic [CPUAWIDTH-1:0] pick_addr;
  logic                 pick_bad;
  int                   j;

  // Scan rr_q, rr_q+1, ... (mod NREQ) for the first requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_q) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  assign pick_addr = addr[int'(pick)*CPUAWIDTH +: CPUAWIDTH];
  assign pick_bad  = (|pick_addr[1:0]) |
                     (|pick_addr[CPUAWIDTH-1:AWIDTH+2]);
  assign pick_nxt  = (int'(pick) == NREQ-1) ? '0 : pick + 1'b1;

  logic [NREQ-1:0] gnt_c, err_c;
  logic            arb;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    we_d      = we_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    gnt_c     = '0;
    err_c     = '0;
    done      = '0;
    rdata     = rdata_q;
    ram_addr  = '0;
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    ram_wdata = '0;
    arb       = 1'b0;
    unique case (state_q)
      IDLE: arb = 1'b1;
      ACCESS: begin
        ram_rd_en = ~we_q;
        ram_wr_en = we_q;
        ram_addr  = waddr_q;
        ram_wdata = wdata_q;
        state_d   = RESP;
      end
      RESP: begin
        done[win_q] = 1'b1;
        if (!we_q) begin
          rdata   = ram_rdata;
          rdata_d = ram_rdata;
        end
        arb     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pointer moves at grant time so a RESP re-arbitration starts past w.
    if (arb && found) begin
      gnt_c[pick] = 1'b1;
      rr_d        = pick_nxt;
      if (pick_bad) begin
        err_c[pick] = 1'b1;
        state_d     = IDLE;
      end else begin
        state_d = ACCESS;
        win_d   = pick;
        we_d    = we[pick];
        waddr_d = pick_addr[AWIDTH+1:2];
        wdata_d = wdata[int'(pick)*DWIDTH +: DWIDTH];
      end
    end
  end

  assign gnt = reset ? '0 : gnt_c;
  assign err = reset ? '0 : err_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
